// File: rtl/ram_word_arbiter.sv
// ram_word_arbiter
// Round-robin arbiter for two 16-bit word masters sharing one byte-wide
// port of the 16K x 8 dual-port block RAM. Requester 0 is the CPU data path
// and requester 1 is the screen/loader engine. Each word is split into two
// byte accesses: the low byte at the even address, then the high byte at the
// odd address.
// The RAM has one cycle of read latency, so the low byte returns while the
// high byte is being addressed. The high byte returns one cycle after that.
module ram_word_arbiter #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-2:0] addr0,
  input  logic [ADDR_W-2:0] addr1,
  input  logic [15:0]       wdata0,
  input  logic [15:0]       wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [15:0]       rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_q
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  state_t            state_r;
  logic              last_r;   // id of the most recent grant; loses the next tie
  logic              id_r;     // requester owning the current transfer
  logic              we_r;
  logic [ADDR_W-2:0] addr_r;
  logic [15:0]       wdata_r;
  logic [7:0]        rd_lo_r;  // low byte held until the high byte arrives

  logic              elig0_s;
  logic              elig1_s;
  logic              grant_s;
  logic              gnt_id_s;

  // Eligibility and round-robin choice. A requester whose ack is high this
  // cycle still has req asserted, so it is masked out to avoid a re-grant.
  always_comb begin
    elig0_s  = req0 & ~ack0;
    elig1_s  = req1 & ~ack1;
    grant_s  = elig0_s | elig1_s;
    gnt_id_s = 1'b0;
    if (elig0_s && elig1_s) begin
      gnt_id_s = ~last_r;
    end else if (elig1_s) begin
      gnt_id_s = 1'b1;
    end else begin
      gnt_id_s = 1'b0;
    end
  end

  // Sequencer: latch the winner's request, step through both byte accesses,
  // then publish the assembled word together with a one-cycle ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      last_r  <= 1'b1;
      id_r    <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= {(ADDR_W-1){1'b0}};
      wdata_r <= 16'h0000;
      rd_lo_r <= 8'h00;
      rdata   <= 16'h0000;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            id_r    <= gnt_id_s;
            last_r  <= gnt_id_s;
            we_r    <= gnt_id_s ? we1    : we0;
            addr_r  <= gnt_id_s ? addr1  : addr0;
            wdata_r <= gnt_id_s ? wdata1 : wdata0;
            state_r <= ST_LO;
            busy    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        ST_LO: begin
          state_r <= ST_HI;
          busy    <= 1'b1;
        end
        ST_HI: begin
          // The RAM has returned the byte addressed during LO.
          rd_lo_r <= ram_q;
          state_r <= ST_FIN;
          busy    <= 1'b1;
        end
        ST_FIN: begin
          // The RAM has returned the byte addressed during HI. On writes
          // the RAM echoes the written data, so this is the written word.
          rdata   <= {ram_q, rd_lo_r};
          ack0    <= ~id_r;
          ack1    <= id_r;
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // RAM port drive. This is decoded from the state and the latched request
  // only, so the write enable can be high only in LO or HI.
  always_comb begin
    ram_addr  = {ADDR_W{1'b0}};
    ram_wdata = 8'h00;
    ram_we    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ram_addr  = {ADDR_W{1'b0}};
        ram_wdata = 8'h00;
        ram_we    = 1'b0;
      end
      ST_LO: begin
        ram_addr  = {addr_r, 1'b0};
        ram_wdata = wdata_r[7:0];
        ram_we    = we_r;
      end
      ST_HI: begin
        ram_addr  = {addr_r, 1'b1};
        ram_wdata = wdata_r[15:8];
        ram_we    = we_r;
      end
      ST_FIN: begin
        ram_addr  = {addr_r, 1'b1};
        ram_wdata = 8'h00;
        ram_we    = 1'b0;
      end
      default: begin
        ram_addr  = {ADDR_W{1'b0}};
        ram_wdata = 8'h00;
        ram_we    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_word_arbiter.sv
// Directed testbench for ram_word_arbiter. It includes a behavioural
// 16K x 8 RAM with registered, write-echo read data.
module tb_ram_word_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [12:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, busy;
  logic [15:0] rdata;
  logic [13:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_q;

  logic [7:0]  mem [0:16383];
  logic        pre_en;
  logic [13:0] pre_addr;
  logic [7:0]  pre_data;

  int checks;
  int errors;

  ram_word_arbiter #(.ADDR_W(14)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM. A write echoes its data on q. The bench also uses a
  // preload port to set up memory contents.
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
      ram_q         <= mem[ram_addr];
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      ram_q         <= ram_wdata;
    end else begin
      ram_q         <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [13:0] a, input logic [7:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  // Issue one word from requester id. Wait up to 12 cycles for its ack.
  // Return the latency in negedges after the drive and the rdata seen in the ack cycle.
  task automatic run_word(input int id, input logic we, input logic [12:0] a,
                          input logic [15:0] wd, input logic drop_early,
                          output int lat, output logic [15:0] rd);
    logic ackv, othv;
    int   oth;
    lat = 0;
    rd  = 16'hxxxx;
    oth = 0;
    if (id == 0) begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd;
    end
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("lo_addr", {18'd0, ram_addr}, {18'd0, a, 1'b0});
        check("lo_we", {31'd0, ram_we}, {31'd0, we});
        check("lo_wdata", {24'd0, ram_wdata}, {24'd0, wd[7:0]});
        check("lo_busy", {31'd0, busy}, 32'd1);
        if (drop_early) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
      if (n == 2) begin
        check("hi_addr", {18'd0, ram_addr}, {18'd0, a, 1'b1});
        check("hi_wdata", {24'd0, ram_wdata}, {24'd0, wd[15:8]});
      end
      ackv = (id == 0) ? ack0 : ack1;
      othv = (id == 0) ? ack1 : ack0;
      if (othv) oth++;
      if (ackv) begin
        lat = n;
        rd  = rdata;
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("other_ack_quiet", oth, 32'd0);
    @(negedge clk);
  endtask

  initial begin : stim
    int          lat;
    logic [15:0] rd;
    int          ord [4];
    int          at  [4];
    int          nack, k0, k1, wecyc, dbl, prev, cnt;
    int          b2b [3];

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 13'd0; addr1 = 13'd0; wdata0 = 16'd0; wdata1 = 16'd0;
    pre_en = 1'b0; pre_addr = 14'd0; pre_data = 8'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ack0", {31'd0, ack0}, 32'd0);
    check("rst_ack1", {31'd0, ack1}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ram_addr", {18'd0, ram_addr}, 32'd0);
    check("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Preload
    poke(14'h0010, 8'h34);
    poke(14'h0011, 8'h12);
    poke(14'h0200, 8'h00);
    poke(14'h0201, 8'h77);

    // Single read
    run_word(0, 1'b0, 13'h0008, 16'h0000, 1'b0, lat, rd);
    check("read_latency", lat, 32'd4);
    check("read_rdata", {16'd0, rd}, 32'h1234);

    // Write to the last word, then read it back
    run_word(1, 1'b1, 13'h1FFF, 16'hBEEF, 1'b0, lat, rd);
    check("wr_latency", lat, 32'd4);
    check("wr_echo", {16'd0, rd}, 32'hBEEF);
    check("wr_byte_lo", {24'd0, mem[16382]}, 32'hEF);
    check("wr_byte_hi", {24'd0, mem[16383]}, 32'hBE);
    run_word(1, 1'b0, 13'h1FFF, 16'h0000, 1'b0, lat, rd);
    check("rb_rdata", {16'd0, rd}, 32'hBEEF);

    // Contention: both requesters write and hold their requests for two words each
    req0 = 1'b1; we0 = 1'b1; addr0 = 13'h0020; wdata0 = 16'h1122;
    req1 = 1'b1; we1 = 1'b1; addr1 = 13'h0030; wdata1 = 16'h5566;
    nack = 0; k0 = 0; k1 = 0; wecyc = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ram_we) wecyc++;
      if (ack0 && nack < 4) begin
        ord[nack] = 0; at[nack] = n; nack++;
        check("cont_rdata0", {16'd0, rdata}, (k0 == 0) ? 32'h1122 : 32'h3344);
        k0++;
        if (k0 == 2) req0 = 1'b0;
        else begin addr0 = 13'h0021; wdata0 = 16'h3344; end
      end
      if (ack1 && nack < 4) begin
        ord[nack] = 1; at[nack] = n; nack++;
        check("cont_rdata1", {16'd0, rdata}, (k1 == 0) ? 32'h5566 : 32'h7788);
        k1++;
        if (k1 == 2) req1 = 1'b0;
        else begin addr1 = 13'h0031; wdata1 = 16'h7788; end
      end
      if (nack == 4) break;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("cont_nack", nack, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("cont_order", (i < nack) ? ord[i] : 32'd9, i % 2);
      check("cont_time", (i < nack) ? at[i] : 32'd0, 4 * (i + 1));
    end
    check("cont_we_cycles", wecyc, 32'd8);
    check("cont_mem40", {24'd0, mem[14'h0040]}, 32'h22);
    check("cont_mem43", {24'd0, mem[14'h0043]}, 32'h33);
    check("cont_mem60", {24'd0, mem[14'h0060]}, 32'h66);
    check("cont_mem63", {24'd0, mem[14'h0063]}, 32'h77);
    @(negedge clk);

    // Back-to-back reads from one requester
    req0 = 1'b1; we0 = 1'b0; addr0 = 13'h0008;
    cnt = 0; dbl = 0; prev = 0;
    b2b[0] = 0; b2b[1] = 0; b2b[2] = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (ack0 && prev != 0) dbl++;
      prev = ack0 ? 1 : 0;
      if (ack0 && cnt < 3) begin
        b2b[cnt] = n; cnt++;
        if (cnt == 3) req0 = 1'b0;
      end
      if (cnt == 3 && !ack0) break;
    end
    req0 = 1'b0;
    check("b2b_first", b2b[0], 32'd4);
    check("b2b_gap1", b2b[1] - b2b[0], 32'd5);
    check("b2b_gap2", b2b[2] - b2b[1], 32'd5);
    check("b2b_double", dbl, 32'd0);
    check("b2b_rdata", {16'd0, rdata}, 32'h1234);
    @(negedge clk);

    // Reset during HI of a write
    req0 = 1'b1; we0 = 1'b1; addr0 = 13'h0100; wdata0 = 16'hA5C3;
    @(negedge clk);
    check("rst_wr_lo_addr", {18'd0, ram_addr}, 32'h0200);
    check("rst_wr_lo_we", {31'd0, ram_we}, 32'd1);
    @(negedge clk);
    check("rst_wr_hi_addr", {18'd0, ram_addr}, 32'h0201);
    #1;
    reset = 1'b1; req0 = 1'b0; we0 = 1'b0;
    #1;
    check("mid_rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("mid_rst_ram_addr", {18'd0, ram_addr}, 32'd0);
    check("mid_rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_rdata", {16'd0, rdata}, 32'd0);
    check("mid_rst_ack0", {31'd0, ack0}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (ack0 || ack1) cnt++;
    end
    check("mid_rst_no_ack", cnt, 32'd0);
    check("mid_rst_byte_lo", {24'd0, mem[14'h0200]}, 32'hC3);
    check("mid_rst_byte_hi", {24'd0, mem[14'h0201]}, 32'h77);
    run_word(0, 1'b0, 13'h0100, 16'h0000, 1'b0, lat, rd);
    check("post_rst_latency", lat, 32'd4);
    check("post_rst_rdata", {16'd0, rd}, 32'h77C3);

    // Abandon: drop req0 during LO
    run_word(0, 1'b0, 13'h0008, 16'h0000, 1'b1, lat, rd);
    check("abandon_latency", lat, 32'd4);
    check("abandon_rdata", {16'd0, rd}, 32'h1234);
    cnt = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (busy || ack0 || ack1) cnt++;
    end
    check("abandon_idle", cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_word_arbiter.md
# ram_word_arbiter

Two-requester arbiter and word sequencer for one port of the 16K x 8 dual-port block RAM. It accepts 16-bit Hack word reads and writes from two masters: requester 0 is the CPU data path and requester 1 is the screen/loader engine. It grants them round-robin and performs each word as two consecutive byte accesses, low byte then high byte. It sits between the masters and one RAM port, with exclusive ownership of that port's addr/data/we/q signals.

## Interface
- ADDR_W, 14, RAM byte-address width; word address width is ADDR_W-1 (13 → 8192 words)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req0 / req1  in  1  request from requester 0 / 1; held high until matching ack
- we0 / we1  in  1  1 = write, 0 = read; sampled at grant
- addr0 / addr1  in  ADDR_W-1  word address; sampled at grant
- wdata0 / wdata1  in  16  write data; sampled at grant
- ack0 / ack1  out  1  one-cycle completion pulse, registered
- rdata  out  16  word result, registered, valid in the ack cycle
- busy  out  1  high in states LO, HI, FIN
- ram_addr  out  ADDR_W  RAM byte address
- ram_wdata  out  8  RAM write data
- ram_we  out  1  RAM write enable
- ram_q  in  8  RAM registered read data; RAM latency is 1 cycle

## Operation
- State machine states: IDLE, LO, HI, FIN. Reset state is IDLE.
- IDLE:
  - Eligible requester: reqN=1 and ackN=0. The ack term masks the requester whose ack is currently high, because its req is still high for that cycle.
  - If no requester is eligible, stay in IDLE.
  - If only one is eligible, grant it.
  - If both are eligible, grant the requester that is not `last`.
  - On grant: latch id, we, addr, wdata; set `last` = id; go to LO.
- LO:
  - ram_addr = {addr, 1'b0}, ram_wdata = wdata[7:0], ram_we = we.
  - Go to HI.
- HI:
  - ram_addr = {addr, 1'b1}, ram_wdata = wdata[15:8], ram_we = we.
  - Capture ram_q into rd_lo. ram_q holds the low byte at this point.
  - Go to FIN.
- FIN:
  - ram_we = 0, ram_addr = {addr, 1'b1}.
  - At the edge: rdata <= {ram_q, rd_lo}, ack[id] <= 1. Go to IDLE.
- Writes also return data:
  - The RAM echoes write data on q, so a write's rdata equals the written word.
  - Requesters must ignore rdata on writes.
- RAM outputs in IDLE: ram_addr = 0, ram_wdata = 0, ram_we = 0. These outputs are combinational from state and latched regs; no other state drives ram_we high.
- Byte order: little-endian; the low byte is at the even address.
- Changes to a requester's inputs after grant have no effect on the current transfer.
- A requester may drop req before ack (abandon). The transfer still completes and its ack still pulses.

## Timing
- Reset values:
  - state = IDLE, last = 1 (requester 0 wins the first tie), rd_lo = 0
  - rdata = 0, ack0 = ack1 = 0, busy = 0
  - ram_addr = 0, ram_wdata = 0, ram_we = 0
- Latency: req sampled at edge E0 (IDLE) → LO in cycle E0..E1, HI in E1..E2, FIN in E2..E3 → ack high in E3..E4. That is 4 cycles from the grant edge to the end of the ack cycle.
- Throughput:
  - The ack cycle is an IDLE cycle and may grant the other requester, so alternating traffic sustains 1 word per 4 cycles.
  - The same requester re-requesting is granted no earlier than the cycle after its ack, giving 1 word per 5 cycles.
- Simultaneous requests alternate strictly 0,1,0,1… while both are held.
- Asynchronous reset mid-transfer:
  - Immediate return to IDLE with all outputs at reset values; no ack is issued.
  - A write interrupted after LO leaves the low byte written and the high byte stale. This partial write is accepted behaviour.
- Address wrap: word 8191 maps to bytes 16382/16383. There is no carry across words and no wrap within a transfer.

## Test plan
- Single read: preload RAM bytes 0x0010=0x34, 0x0011=0x12; req0 read addr0=0x0008 → ack0 pulses exactly 4 cycles after the grant edge, rdata=0x1234, ack1 stays 0.
- Write then readback: req1 write addr1=0x1FFF, wdata1=0xBEEF → RAM byte 16382=0xEF, 16383=0xBE, rdata=0xBEEF; then req1 read 0x1FFF → rdata=0xBEEF.
- Contention: req0 and req1 both rise in the same cycle and stay high for 4 transfers → grant order 0,1,0,1; acks 4 cycles apart; ram_we never high in IDLE.
- Back-to-back same requester: req0 held continuously with req1=0 → successive ack0 pulses 5 cycles apart, never a double pulse.
- Reset mid-write: assert reset during HI of a write of 0xA5C3 to word 0x0100 → outputs zero immediately, no ack; byte 0x0200=0xC3, byte 0x0201 unchanged; the next request after deassert completes normally.
- Abandon: req0 dropped in LO → ack0 still pulses 4 cycles after the grant edge, and the FSM then idles.
